store_unit: RTL and testbench

- MEM-stage store path for the MIPS pipeline; write-direction counterpart of the load filter/extension path that feeds the writeback mux.
- Takes SB/SH/SW requests and checks alignment.
- Lane-aligns the data and generates byte enables.
- Queues stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Stalls the pipeline when the FIFO is full and flags load-after-store hazards on pending words.

---
 rtl/store_unit.sv | 144 ++++++++++++++
 tb/tb_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// MEM-stage store path: checks SB/SH/SW alignment, lane-aligns data with byte enables,
// and buffers stores in a small FIFO drained to data memory over a req/ack handshake.
module store_unit #(
  parameter int BITS_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [1:0]           i_store_size,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [BITS_SIZE-1:0] i_data,
  output logic                 o_stall,
  output logic                 o_misaligned,
  input  logic                 i_load_valid,
  input  logic [ADDR_SIZE-1:0] i_load_addr,
  output logic                 o_load_hazard,
  output logic                 o_mem_req,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [BITS_SIZE-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_be,
  input  logic                 i_mem_ack,
  output logic                 o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_SIZE - 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic [WA_W-1:0]      waddr;
    logic [BITS_SIZE-1:0] wdata;
    logic [3:0]           be;
  } entry_t;

  entry_t             buf_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               misaligned_q;

  logic               aligned;
  logic [BITS_SIZE-1:0] lane_data;
  logic [3:0]         lane_be;
  logic               full;
  logic               accept;
  logic               pop;
  logic               hazard;

  // NOTE: every always_comb output gets a default up front so no path can infer a latch.
  always_comb begin
    aligned   = 1'b0;
    lane_data = '0;
    lane_be   = '0;
    case (size_e'(i_store_size))
      SZ_BYTE: begin
        aligned   = 1'b1;
        lane_data = {4{i_data[7:0]}};
        lane_be   = 4'b0001 << i_addr[1:0];
      end
      SZ_HALF: begin
        aligned   = ~i_addr[0];
        lane_data = {2{i_data[15:0]}};
        lane_be   = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        aligned   = (i_addr[1:0] == 2'b00);
        lane_data = i_data;
        lane_be   = 4'b1111;
      end
      default: ;
    endcase
  end

  // A full buffer refuses even when the head pops this cycle; the pipeline just retries.
  assign full    = (count == CNT_W'(DEPTH));
  assign accept  = i_valid & aligned & ~full;
  assign pop     = o_mem_req & i_mem_ack;
  assign o_stall = i_valid & aligned & full;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      valid_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= i_valid & ~aligned;
      if (accept) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the payload array has no reset; valid_q and count alone decide what is live.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      buf_q[wr_ptr] <= '{waddr: i_addr[ADDR_SIZE-1:2], wdata: lane_data, be: lane_be};
    end
  end

  // The entry being popped this cycle is still valid, so it still blocks a matching load.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (buf_q[i].waddr == i_load_addr[ADDR_SIZE-1:2])) begin
        hazard = 1'b1;
      end
    end
  end

  logic unused_load_lsbs;
  assign unused_load_lsbs = ^i_load_addr[1:0];

  assign o_load_hazard = i_load_valid & hazard;
  assign o_misaligned  = misaligned_q;
  assign o_mem_req     = (count != '0);
  assign o_empty       = (count == '0);
  assign o_mem_addr    = {buf_q[rd_ptr].waddr, 2'b00};
  assign o_mem_wdata   = buf_q[rd_ptr].wdata;
  assign o_mem_be      = buf_q[rd_ptr].be;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: queue-based reference model compared every cycle,
// directed lane/misalign/full/hazard/reset scenarios, then randomized traffic.
module tb_store_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [1:0]  i_store_size;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        o_stall;
  logic        o_misaligned;
  logic        i_load_valid;
  logic [31:0] i_load_addr;
  logic        o_load_hazard;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic        o_empty;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  store_unit #(.BITS_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .i_store_size (i_store_size),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_stall      (o_stall),
    .o_misaligned (o_misaligned),
    .i_load_valid (i_load_valid),
    .i_load_addr  (i_load_addr),
    .o_load_hazard(o_load_hazard),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_ack    (i_mem_ack),
    .o_empty      (o_empty)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  logic exp_mis;

  function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return a[0] == 1'b0;
      2'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Access of 2^sz bytes starting at lane a[1:0]; each lane j carries data byte (j mod width).
  function automatic ent_t make_entry(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] d);
    ent_t e;
    int nb = 1 << sz;
    e.addr = {a[31:2], 2'b00};
    e.be   = 4'(((1 << nb) - 1) << a[1:0]);
    for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = d[8*(j % nb) +: 8];
    return e;
  endfunction

  task automatic model_step();
    bit acc;
    bit pop;
    acc = i_valid && legal(i_store_size, i_addr) && (q.size() < DEPTH);
    pop = (q.size() != 0) && i_mem_ack;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(make_entry(i_store_size, i_addr, i_data));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_mis <= 1'b0;
    end else begin
      exp_mis <= i_valid && !legal(i_store_size, i_addr);
      model_step();
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    bit haz;
    haz = 1'b0;
    foreach (q[k]) if (q[k].addr[31:2] == i_load_addr[31:2]) haz = 1'b1;
    check("mem_req", o_mem_req, q.size() != 0);
    check("empty", o_empty, q.size() == 0);
    check("misaligned", o_misaligned, exp_mis);
    check("stall", o_stall, i_valid && legal(i_store_size, i_addr) && q.size() == DEPTH);
    check("load_hazard", o_load_hazard, i_load_valid && haz);
    if (q.size() != 0) begin
      check("mem_addr", o_mem_addr, q[0].addr);
      check("mem_wdata", o_mem_wdata, q[0].wdata);
      check("mem_be", o_mem_be, q[0].be);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    i_valid      = 1'b1;
    i_store_size = sz;
    i_addr       = a;
    i_data       = d;
  endtask

  task automatic lane_check(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb);
    i_mem_ack = 1'b0;
    drive(sz, a, d);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("lane_req", o_mem_req, 1);
    check("lane_addr", o_mem_addr, ea);
    check("lane_wdata", o_mem_wdata, ed);
    check("lane_be", {28'd0, o_mem_be}, {28'd0, eb});
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
  endtask

  task automatic mis_check(input logic [1:0] sz, input logic [31:0] a);
    drive(sz, a, 32'hDEAD_BEEF);
    @(negedge clk);
    check("mis_no_stall", o_stall, 0);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("mis_pulse", o_misaligned, 1);
    check("mis_empty", o_empty, 1);
    tick();
    @(negedge clk);
    check("mis_pulse_end", o_misaligned, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_store_size = 2'b00;
    i_addr       = '0;
    i_data       = '0;
    i_load_valid = 1'b0;
    i_load_addr  = '0;
    i_mem_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req", o_mem_req, 0);
    check("rst_empty", o_empty, 1);
    check("rst_mis", o_misaligned, 0);

    // Lane alignment
    lane_check(2'b00, 32'h103, 32'h0000_00AB, 32'h100, 32'hABAB_ABAB, 4'b1000);
    lane_check(2'b01, 32'h202, 32'h0000_1234, 32'h200, 32'h1234_1234, 4'b1100);
    lane_check(2'b10, 32'h300, 32'hCAFE_F00D, 32'h300, 32'hCAFE_F00D, 4'b1111);

    // Misalignment
    mis_check(2'b01, 32'h201);
    mis_check(2'b10, 32'h302);
    mis_check(2'b11, 32'h300);

    // Full / backpressure
    i_mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 32'h10 + 32'(4 * i), 32'(i + 1));
      tick();
    end
    drive(2'b10, 32'h20, 32'd5);
    @(negedge clk);
    check("full_stall", o_stall, 1);
    @(posedge clk);
    #1 i_mem_ack = 1'b1;
    @(negedge clk);
    check("full_stall_ack", o_stall, 1);
    @(posedge clk);
    #1 i_mem_ack = 1'b0;
    @(negedge clk);
    check("full_retry", o_stall, 0);
    tick();
    i_valid   = 1'b0;
    i_mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fifo_order", o_mem_addr, 32'h14 + 32'(4 * i));
      tick();
    end
    i_mem_ack = 1'b0;
    @(negedge clk);
    check("full_drained", o_empty, 1);

    // Continuous SB stream with ack held high, then with ack gaps
    i_mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(2'b00, $urandom & 32'hFFF, $urandom);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(2'b00, $urandom & 32'hFFF, $urandom);
      i_mem_ack = (i % 4 != 2);
      tick();
    end
    i_valid   = 1'b0;
    i_mem_ack = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("stream_drained", o_empty, 1);

    // Load-after-store hazard
    i_mem_ack = 1'b0;
    drive(2'b10, 32'h400, 32'h1111_2222);
    tick();
    i_valid      = 1'b0;
    i_load_valid = 1'b1;
    i_load_addr  = 32'h402;
    @(negedge clk);
    check("haz_same_word", o_load_hazard, 1);
    i_load_addr = 32'h404;
    #1 check("haz_next_word", o_load_hazard, 0);
    i_load_addr = 32'h402;
    i_mem_ack   = 1'b1;
    #1 check("haz_pop_cycle", o_load_hazard, 1);
    tick();
    i_mem_ack = 1'b0;
    @(negedge clk);
    check("haz_after_ack", o_load_hazard, 0);
    i_load_valid = 1'b0;

    // Reset mid-stream with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 32'h500 + 32'(4 * i), 32'(i));
      tick();
    end
    i_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check("mid_rst_req", o_mem_req, 0);
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_mis", o_misaligned, 0);
    tick();
    rst_n = 1'b1;
    drive(2'b10, 32'h600, 32'h0BAD_F00D);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("post_rst_addr", o_mem_addr, 32'h600);
    check("post_rst_wdata", o_mem_wdata, 32'h0BAD_F00D);
    i_mem_ack = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      i_valid      = ($urandom_range(0, 9) < 7);
      i_store_size = 2'($urandom_range(0, 3));
      i_addr       = $urandom & 32'h3F;
      i_data       = $urandom;
      i_load_valid = $urandom_range(0, 1);
      i_load_addr  = $urandom & 32'h3F;
      i_mem_ack    = ($urandom_range(0, 9) < 4);
      rst_n        = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n        = 1'b1;
    i_valid      = 1'b0;
    i_load_valid = 1'b0;
    i_mem_ack    = 1'b1;
    repeat (DEPTH + 2) tick();
    @(negedge clk);
    check("final_empty", o_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
